uart_rx: RTL and testbench
==========================

UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 SHALL have parameter FRAME_WIDTH, default 8, data bits per frame.
REQ-002 SHALL have parameter PRESCALE_WIDTH, default 6, width of the Prescale port.
REQ-003 SHALL have port clk  input  1  single clock; all logic on its rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port RX_IN  input  1  serial line, idle high, LSB-first frames.
REQ-006 SHALL have port Prescale  input  PRESCALE_WIDTH  clk cycles per bit: 8, 16 or 32.
REQ-007 SHALL have port par_en  input  1  frame carries a parity bit.
REQ-008 SHALL have port PAR_TYP  input  1  0 = even, 1 = odd parity.
REQ-009 SHALL have port P_DATA  output  FRAME_WIDTH  last received data word.
REQ-010 SHALL have port Data_Valid  output  1  one-cycle pulse when P_DATA holds a good frame.
REQ-011 SHALL have port par_err  output  1  parity mismatch flag for the current frame.
REQ-012 SHALL have port stp_err  output  1  stop bit sampled low for the current frame.
REQ-013 SHALL have port busy  output  1  high whenever the FSM is not in IDLE.

Function
REQ-014 SHALL pass RX_IN through a 2-flop synchronizer; all sampling uses the synchronized value.
REQ-015 SHALL run FSM states IDLE, START, DATA, PARITY, STOP.
REQ-016 IDLE -> START on the first synchronized low; edge counter cleared; par_en, PAR_TYP and Prescale latched.
REQ-017 SHALL count edges 0..Prescale-1 per bit; bit counter advances when the edge count equals Prescale-1.
REQ-018 SHALL sample at edge counts Prescale/2-1, Prescale/2 and Prescale/2+1; bit value = majority of the three.
REQ-019 START: a majority value of 1 SHALL be a glitch and return the FSM to IDLE at bit end, with no flags and no Data_Valid.
REQ-020 DATA: SHALL shift FRAME_WIDTH bits LSB first, then go to PARITY if the latched par_en is 1, else STOP.
REQ-021 PARITY: SHALL set par_err if the sampled bit differs from XOR(data) (even) or ~XOR(data) (odd).
REQ-022 STOP: SHALL set stp_err if the majority value is 0.
REQ-023 SHALL assert Data_Valid for exactly one cycle, one cycle after the third stop-bit sample, only when par_err and stp_err are both 0.
REQ-024 SHALL update P_DATA in the same cycle as Data_Valid and hold it until the next good frame.
REQ-025 par_err and stp_err SHALL hold until the next START entry, which clears both.
REQ-026 After the STOP bit ends, SHALL go to IDLE; a low already present SHALL start a new frame on the next cycle (back-to-back frames).
REQ-027 A Prescale value other than 8, 16 or 32 SHALL be treated as 8.
REQ-028 Port changes mid-frame SHALL NOT affect the frame in progress.

Reset
REQ-029 reset SHALL force IDLE, clear all counters and shift registers, set both synchronizer flops to 1, and set P_DATA=0, Data_Valid=0, par_err=0, stp_err=0, busy=0.
REQ-030 Reset asserted mid-frame SHALL abort the frame with no Data_Valid pulse; reception restarts on the first low after release.

Configuration
REQ-031 Macro UART_RX_PARITY_EN defined: the PARITY state and par_err operate per REQ-020/021.
REQ-032 UART_RX_PARITY_EN undefined: par_en and PAR_TYP SHALL be ignored, the PARITY state SHALL be omitted, DATA SHALL go to STOP, and par_err SHALL be tied 0.

Structure
REQ-033 Package uart_rx_pkg SHALL hold the FSM state typedef, the PRESCALE_8/16/32 constants and the parity-type constants (EVEN=0, ODD=1).
REQ-034 Sub-module data_sampling SHALL implement REQ-018: edge count and Prescale in, majority bit and sample-done strobe out.

Verification
REQ-035 Prescale=8, par_en=0, send 0xA5 -> P_DATA=0xA5, Data_Valid high for 1 cycle, errors 0.
REQ-036 Prescale=16, par_en=1, PAR_TYP=0, send 0x3C with parity 0 -> P_DATA=0x3C, Data_Valid pulse; repeat with parity 1 -> par_err=1, no Data_Valid.
REQ-037 Prescale=32, send 0x81 with stop bit 0 -> stp_err=1, no Data_Valid, P_DATA keeps its prior value.
REQ-038 RX_IN low for 2 cycles at Prescale=8 -> returns to IDLE, no flags, no Data_Valid.
REQ-039 Back-to-back 0x55 then 0xAA at Prescale=8 with no idle gap -> two Data_Valid pulses, values in order.
REQ-040 reset asserted in the DATA state of frame 0xF0 -> all outputs 0 next cycle; next frame 0x0F received correctly.

Source files
------------

// File: rtl/uart_rx_pkg.sv
// Shared types and constants for the UART receiver.
// The PARITY state exists only when UART_RX_PARITY_EN is defined.
package uart_rx_pkg;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      START  = 3'd1,
      DATA   = 3'd2,
`ifdef UART_RX_PARITY_EN
      PARITY = 3'd3,
`endif
      STOP   = 3'd4
   } state_t;

   localparam int PRESCALE_8  = 8;
   localparam int PRESCALE_16 = 16;
   localparam int PRESCALE_32 = 32;

   localparam logic EVEN = 1'b0;
   localparam logic ODD  = 1'b1;

endpackage

// File: rtl/uart_rx_data_sampling.sv
// Mid-bit oversampler: takes three samples around the bit centre and
// reports their majority together with a strobe on the third sample.
module data_sampling #(
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      i_rx,
   input  logic [PRESCALE_WIDTH-1:0] i_edge_cnt,
   input  logic [PRESCALE_WIDTH-1:0] i_prescale,
   output logic                      o_bit,
   output logic                      o_done
);

   logic [PRESCALE_WIDTH-1:0] w_mid;
   logic                      r_s0, r_s1;

   assign w_mid = i_prescale >> 1;

   always_ff @(posedge clk) begin
      if (reset) begin
         r_s0 <= 1'b0;
         r_s1 <= 1'b0;
      end else begin
         if (i_edge_cnt == w_mid - PRESCALE_WIDTH'(1)) r_s0 <= i_rx;
         if (i_edge_cnt == w_mid)                      r_s1 <= i_rx;
      end
   end

   // Third sample is used live so the result is available on its own cycle.
   assign o_done = (i_edge_cnt == w_mid + PRESCALE_WIDTH'(1));
   assign o_bit  = (r_s0 & r_s1) | (r_s0 & i_rx) | (r_s1 & i_rx);

endmodule

// File: rtl/uart_rx.sv
// UART receiver: 2-flop synchronizer, oversampling FSM, parity/stop checks.
// Optional parity support is compiled in with UART_RX_PARITY_EN.
module uart_rx
   import uart_rx_pkg::*;
#(
   parameter int FRAME_WIDTH    = 8,
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic                      RX_IN,
   input  logic [PRESCALE_WIDTH-1:0] Prescale,
   input  logic                      par_en,
   input  logic                      PAR_TYP,
   output logic [FRAME_WIDTH-1:0]    P_DATA,
   output logic                      Data_Valid,
   output logic                      par_err,
   output logic                      stp_err,
   output logic                      busy
);

   localparam int BCW = (FRAME_WIDTH > 1) ? $clog2(FRAME_WIDTH) : 1;

   state_t                    r_state;
   logic                      r_sync1, r_sync2;
   logic                      w_rx;
   logic [PRESCALE_WIDTH-1:0] r_edge_cnt, r_prescale, w_prescale_norm;
   logic [BCW-1:0]            r_bit_cnt;
   logic [FRAME_WIDTH-1:0]    r_shift, r_p_data;
   logic                      r_data_valid, r_stp_err, r_busy, r_bit;
   logic                      w_bit, w_done, w_bit_end, w_good;

`ifdef UART_RX_PARITY_EN
   logic                      r_par_en, r_par_typ, r_par_err;
   assign w_good  = ~r_par_err;
   assign par_err = r_par_err;
`else
   logic                      w_unused;
   assign w_unused = &{1'b0, par_en, PAR_TYP};
   assign w_good   = 1'b1;
   assign par_err  = 1'b0;
`endif

   assign w_rx      = r_sync2;
   assign w_bit_end = (r_edge_cnt == r_prescale - PRESCALE_WIDTH'(1));

   // Anything other than 16 or 32 falls back to 8 cycles per bit.
   assign w_prescale_norm =
      (Prescale == PRESCALE_WIDTH'(PRESCALE_16) || Prescale == PRESCALE_WIDTH'(PRESCALE_32))
      ? Prescale : PRESCALE_WIDTH'(PRESCALE_8);

   data_sampling #(.PRESCALE_WIDTH(PRESCALE_WIDTH)) u_sampler (
      .clk        (clk),
      .reset      (reset),
      .i_rx       (w_rx),
      .i_edge_cnt (r_edge_cnt),
      .i_prescale (r_prescale),
      .o_bit      (w_bit),
      .o_done     (w_done)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state      <= IDLE;
         r_sync1      <= 1'b1;
         r_sync2      <= 1'b1;
         r_edge_cnt   <= '0;
         r_prescale   <= '0;
         r_bit_cnt    <= '0;
         r_shift      <= '0;
         r_p_data     <= '0;
         r_data_valid <= 1'b0;
         r_stp_err    <= 1'b0;
         r_busy       <= 1'b0;
         r_bit        <= 1'b0;
`ifdef UART_RX_PARITY_EN
         r_par_en     <= 1'b0;
         r_par_typ    <= 1'b0;
         r_par_err    <= 1'b0;
`endif
      end else begin
         r_sync1      <= RX_IN;
         r_sync2      <= r_sync1;
         r_data_valid <= 1'b0;
         if (w_done) r_bit <= w_bit;
         if (r_state != IDLE)
            r_edge_cnt <= w_bit_end ? '0 : r_edge_cnt + PRESCALE_WIDTH'(1);

         case (r_state)
            IDLE: begin
               if (!w_rx) begin
                  r_state    <= START;
                  r_edge_cnt <= '0;
                  r_bit_cnt  <= '0;
                  r_prescale <= w_prescale_norm;
                  r_stp_err  <= 1'b0;
                  r_busy     <= 1'b1;
`ifdef UART_RX_PARITY_EN
                  r_par_en   <= par_en;
                  r_par_typ  <= PAR_TYP;
                  r_par_err  <= 1'b0;
`endif
               end
            end
            START: begin
               // A start bit that reads high at mid-bit was a glitch.
               if (w_bit_end) begin
                  if (r_bit) begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end else begin
                     r_state <= DATA;
                  end
               end
            end
            DATA: begin
               if (w_done) r_shift <= {w_bit, r_shift[FRAME_WIDTH-1:1]};
               if (w_bit_end) begin
                  if (r_bit_cnt == BCW'(FRAME_WIDTH - 1)) begin
                     r_bit_cnt <= '0;
`ifdef UART_RX_PARITY_EN
                     r_state   <= r_par_en ? PARITY : STOP;
`else
                     r_state   <= STOP;
`endif
                  end else begin
                     r_bit_cnt <= r_bit_cnt + BCW'(1);
                  end
               end
            end
`ifdef UART_RX_PARITY_EN
            PARITY: begin
               if (w_done) r_par_err <= w_bit ^ (^r_shift) ^ (r_par_typ == ODD);
               if (w_bit_end) r_state <= STOP;
            end
`endif
            STOP: begin
               if (w_done) begin
                  if (!w_bit) begin
                     r_stp_err <= 1'b1;
                  end else if (w_good) begin
                     r_data_valid <= 1'b1;
                     r_p_data     <= r_shift;
                  end
               end
               if (w_bit_end) begin
                  r_state <= IDLE;
                  r_busy  <= 1'b0;
               end
            end
            default: begin
               r_state <= IDLE;
               r_busy  <= 1'b0;
            end
         endcase
      end
   end

   assign P_DATA     = r_p_data;
   assign Data_Valid = r_data_valid;
   assign stp_err    = r_stp_err;
   assign busy       = r_busy;

endmodule

// File: tb/tb_uart_rx.sv
// Directed bench for uart_rx: good frames, parity/stop errors, glitch,
// back-to-back frames, mid-frame reset and Prescale fallback.
module tb_uart_rx;

   logic       clk = 1'b0;
   logic       reset;
   logic       RX_IN;
   logic [5:0] Prescale;
   logic       par_en, PAR_TYP;
   logic [7:0] P_DATA;
   logic       Data_Valid, par_err, stp_err, busy;

   int total = 0;
   int bad   = 0;
   int dv_cnt = 0;
   int dv_base;
   logic [7:0] dv_log[$];

   always #5 clk = ~clk;

   uart_rx dut (
      .clk(clk), .reset(reset), .RX_IN(RX_IN), .Prescale(Prescale),
      .par_en(par_en), .PAR_TYP(PAR_TYP), .P_DATA(P_DATA),
      .Data_Valid(Data_Valid), .par_err(par_err), .stp_err(stp_err), .busy(busy)
   );

   always @(negedge clk) begin
      if (Data_Valid) begin
         dv_cnt++;
         dv_log.push_back(P_DATA);
      end
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic idle(input int n);
      RX_IN = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [7:0] d, input int p, input bit with_par,
                             input logic par, input logic stp, input bit chg_pre);
      RX_IN = 1'b0;
      repeat (p) @(negedge clk);
      if (chg_pre) Prescale = 6'd8;
      for (int i = 0; i < 8; i++) begin
         RX_IN = d[i];
         repeat (p) @(negedge clk);
      end
      if (with_par) begin
         RX_IN = par;
         repeat (p) @(negedge clk);
      end
      RX_IN = stp;
      repeat (p) @(negedge clk);
      RX_IN = 1'b1;
   endtask

   initial begin
      reset = 1'b1; RX_IN = 1'b1; Prescale = 6'd8; par_en = 1'b0; PAR_TYP = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_pdata", P_DATA, 8'h00);
      chk("rst_dv", Data_Valid, 1'b0);
      chk("rst_par", par_err, 1'b0);
      chk("rst_stp", stp_err, 1'b0);
      chk("rst_busy", busy, 1'b0);
      reset = 1'b0;
      idle(4);

      // 0xA5 at Prescale 8, no parity
      dv_base = dv_cnt;
      send_frame(8'hA5, 8, 0, 1'b0, 1'b1, 0);
      idle(16);
      chk("a5_dv", dv_cnt - dv_base, 1);
      chk("a5_log", dv_log[dv_log.size()-1], 8'hA5);
      chk("a5_pdata", P_DATA, 8'hA5);
      chk("a5_stp", stp_err, 1'b0);
      chk("a5_par", par_err, 1'b0);
      chk("a5_busy", busy, 1'b0);

      // 0x3C at Prescale 16 with parity enabled
      Prescale = 6'd16; par_en = 1'b1; PAR_TYP = 1'b0;
      dv_base = dv_cnt;
`ifdef UART_RX_PARITY_EN
      send_frame(8'h3C, 16, 1, 1'b0, 1'b1, 0);
      idle(32);
      chk("3c_even_dv", dv_cnt - dv_base, 1);
      chk("3c_even_pdata", P_DATA, 8'h3C);
      chk("3c_even_par", par_err, 1'b0);
      send_frame(8'h3C, 16, 1, 1'b1, 1'b1, 0);
      idle(32);
      chk("3c_bad_dv", dv_cnt - dv_base, 1);
      chk("3c_bad_par", par_err, 1'b1);
      chk("3c_bad_pdata", P_DATA, 8'h3C);
      PAR_TYP = 1'b1;
      send_frame(8'h3C, 16, 1, 1'b1, 1'b1, 0);
      idle(32);
      chk("3c_odd_dv", dv_cnt - dv_base, 2);
      chk("3c_odd_par", par_err, 1'b0);
`else
      send_frame(8'h3C, 16, 0, 1'b0, 1'b1, 0);
      idle(32);
      chk("3c_dv", dv_cnt - dv_base, 1);
      chk("3c_pdata", P_DATA, 8'h3C);
      chk("3c_par", par_err, 1'b0);
      PAR_TYP = 1'b1;
      send_frame(8'hC3, 16, 0, 1'b0, 1'b1, 0);
      idle(32);
      chk("c3_dv", dv_cnt - dv_base, 2);
      chk("c3_pdata", P_DATA, 8'hC3);
      chk("c3_par", par_err, 1'b0);
      send_frame(8'h3C, 16, 0, 1'b0, 1'b1, 0);
      idle(32);
`endif
      chk("pre37_pdata", P_DATA, 8'h3C);

      // 0x81 at Prescale 32 with a bad stop bit; Prescale port changed mid-frame
      Prescale = 6'd32; par_en = 1'b0; PAR_TYP = 1'b0;
      dv_base = dv_cnt;
      send_frame(8'h81, 32, 0, 1'b0, 1'b0, 1);
      idle(64);
      chk("81_stp", stp_err, 1'b1);
      chk("81_dv", dv_cnt - dv_base, 0);
      chk("81_pdata", P_DATA, 8'h3C);
      chk("81_par", par_err, 1'b0);
      chk("81_busy", busy, 1'b0);

      // 2-cycle glitch at Prescale 8: START entry clears the old stp_err
      Prescale = 6'd8;
      dv_base = dv_cnt;
      RX_IN = 1'b0;
      repeat (2) @(negedge clk);
      idle(3);
      chk("glitch_busy_mid", busy, 1'b1);
      idle(20);
      chk("glitch_busy", busy, 1'b0);
      chk("glitch_stp", stp_err, 1'b0);
      chk("glitch_par", par_err, 1'b0);
      chk("glitch_dv", dv_cnt - dv_base, 0);

      // back-to-back 0x55, 0xAA
      dv_base = dv_cnt;
      send_frame(8'h55, 8, 0, 1'b0, 1'b1, 0);
      send_frame(8'hAA, 8, 0, 1'b0, 1'b1, 0);
      idle(16);
      chk("b2b_dv", dv_cnt - dv_base, 2);
      chk("b2b_first", dv_log[dv_log.size()-2], 8'h55);
      chk("b2b_second", dv_log[dv_log.size()-1], 8'hAA);
      chk("b2b_pdata", P_DATA, 8'hAA);

      // reset in the DATA state of frame 0xF0
      dv_base = dv_cnt;
      RX_IN = 1'b0;
      repeat (8 * 4) @(negedge clk);
      chk("rst_mid_busy", busy, 1'b1);
      reset = 1'b1; RX_IN = 1'b1;
      @(negedge clk);
      chk("rst_mid_pdata", P_DATA, 8'h00);
      chk("rst_mid_dv", Data_Valid, 1'b0);
      chk("rst_mid_busy0", busy, 1'b0);
      chk("rst_mid_stp", stp_err, 1'b0);
      chk("rst_mid_par", par_err, 1'b0);
      reset = 1'b0;
      idle(16);
      chk("rst_mid_nodv", dv_cnt - dv_base, 0);
      send_frame(8'h0F, 8, 0, 1'b0, 1'b1, 0);
      idle(16);
      chk("0f_dv", dv_cnt - dv_base, 1);
      chk("0f_pdata", P_DATA, 8'h0F);

      // unsupported Prescale falls back to 8
      Prescale = 6'd12;
      dv_base = dv_cnt;
      send_frame(8'h5A, 8, 0, 1'b0, 1'b1, 0);
      idle(16);
      chk("ps12_dv", dv_cnt - dv_base, 1);
      chk("ps12_pdata", P_DATA, 8'h5A);
      chk("ps12_stp", stp_err, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
